roce_qp_responder: RTL
======================

Name: roce_qp_responder

Overview:
- Responder-side queue-pair state for RoCEv2 RC RDMA WRITE.
- Consumes decoded RX BTH/RETH headers addressed to the local QP.
- Tracks expected PSN (ePSN), MSN and message sequencing.
- Emits ACK/NAK BTH+AETH descriptors toward the TX header builder. It is the counterpart of the requester QP state logic, which issues WRITEs and consumes ACKs.

Parameters:
- ADDR_WIDTH, 64, width of the RETH virtual address tracked and exported.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-low.
- rst_qp  in  1  synchronous active-high QP re-init: loads qp_init_* and clears state, same cycle effect as reset.
- qp_init_loc_qpn  in  24  local QPN; packets with other dest_qp are ignored.
- qp_init_rem_qpn  in  24  remote QPN; used as dest_qp of generated ACKs.
- qp_init_epsn  in  24  initial expected PSN.
- qp_init_r_key  in  32  valid r_key.
- s_roce_rx_bth_valid  in  1  RX header valid.
- s_roce_rx_bth_ready  out  1  RX header ready.
- s_roce_rx_bth_op_code  in  8  opcode.
- s_roce_rx_bth_psn  in  24  PSN.
- s_roce_rx_bth_dest_qp  in  24  destination QP.
- s_roce_rx_bth_ack_req  in  1  AckReq bit.
- s_roce_rx_reth_valid  in  1  RETH present, qualified by bth_valid.
- s_roce_rx_reth_v_addr  in  64  RETH virtual address.
- s_roce_rx_reth_r_key  in  32  RETH r_key.
- s_roce_rx_reth_length  in  32  RETH DMA length.
- m_roce_ack_valid  out  1  ACK descriptor valid.
- m_roce_ack_ready  in  1  ACK descriptor ready.
- m_roce_ack_op_code  out  8  always 0x11.
- m_roce_ack_psn  out  24  ACK/NAK PSN.
- m_roce_ack_dest_qp  out  24  rem_qpn.
- m_roce_ack_syndrome  out  8  AETH syndrome.
- m_roce_ack_msn  out  24  AETH MSN.
- qp_epsn  out  24  current ePSN.
- qp_msn  out  24  current MSN.
- qp_wr_addr  out  ADDR_WIDTH  v_addr latched from last FIRST/ONLY.
- qp_wr_length  out  32  length latched from last FIRST/ONLY.
- msg_done  out  1  one-cycle pulse when a LAST/ONLY is accepted in order.
- nak_active  out  1  high while in NAK_WAIT.

Behaviour:
- Reset values (rst low or rst_qp high):
  - ePSN = qp_init_epsn, MSN = 0, state IDLE.
  - All outputs 0 except qp_epsn = qp_init_epsn.
  - Pending ACK is dropped.
- Handshake:
  - s_roce_rx_bth_ready = !m_roce_ack_valid || m_roce_ack_ready.
  - A header is accepted on valid && ready. It is processed only when dest_qp == loc_qpn; otherwise it is consumed with no effect.
- Sequence check: d = (psn - ePSN) mod 2^24.
  - d == 0: in order.
  - 1 <= d <= 0x7FFFFF: ahead.
  - Otherwise: duplicate. Wrap across 0xFFFFFF→0 is handled by the modular subtraction.
- States:
  - IDLE (between messages).
  - IN_MSG (after FIRST).
  - NAK_WAIT (NAK sent, awaiting retransmit).
- In-order packet, state IDLE or IN_MSG:
  - FIRST/ONLY valid only in IDLE and only with reth_valid. MIDDLE/LAST valid only in IN_MSG. Violation → NAK 0x61 (invalid request), PSN = ePSN, enter NAK_WAIT, ePSN unchanged.
  - r_key mismatch on FIRST/ONLY (when check enabled) → NAK 0x62 (remote access), PSN = ePSN, enter NAK_WAIT.
  - Valid packet:
    - ePSN += 1.
    - FIRST → IN_MSG. LAST/ONLY → IDLE, MSN += 1, msg_done pulse.
    - FIRST/ONLY latch v_addr[ADDR_WIDTH-1:0] and length.
    - If ack_req, or op is LAST/ONLY: ACK, syndrome 0x1F, PSN = received PSN, MSN = updated MSN.
- Ahead packet:
  - Outside NAK_WAIT → NAK 0x60 (PSN sequence error), PSN = ePSN, enter NAK_WAIT.
  - In NAK_WAIT → silently dropped; no repeated NAK.
- NAK_WAIT exits only on an in-order FIRST/ONLY. The packet is then processed as in IDLE, and the state returns to IDLE/IN_MSG.
- Duplicate packet: if ack_req, re-ACK with syndrome 0x1F, PSN = ePSN-1, current MSN. No state change.
- ACK register:
  - m_roce_ack_* is valid 1 cycle after the accepting edge.
  - It holds stable until ready.
  - A new descriptor may load in the same cycle the old one is consumed.
- Arithmetic: ePSN and MSN wrap mod 2^24.
- Unknown opcodes to the local QP → NAK 0x61.

Optional Feature:
- Macro: ROCE_RESP_RKEY_CHECK_EN.
- Defined: RETH r_key is compared against qp_init_r_key on FIRST/ONLY; a mismatch produces NAK 0x62 as above.
- Undefined: no comparison is made, and r_key is never a cause of NAK.

Test Plan:
- Init ePSN=0x000010. Send FIRST(0x10, reth v_addr=0x1000, len=4096), MIDDLE(0x11), LAST(0x12, ack_req=1) → one ACK: psn=0x12, syndrome 0x1F, msn=1. qp_epsn=0x13. msg_done pulses once. qp_wr_addr=0x1000.
- ePSN=0x20. Send ONLY psn=0x22 → NAK psn=0x20, syndrome 0x60, nak_active=1. Then ONLY 0x23 → no output. Then ONLY 0x20 → ACK psn=0x20, nak_active=0.
- ePSN=0xFFFFFF. Send FIRST 0xFFFFFF, LAST 0x000000 → ACK psn=0x000000, qp_epsn=0x000001.
- ePSN=0x30. Send duplicate ONLY psn=0x2E with ack_req → ACK psn=0x2F, msn unchanged, ePSN stays 0x30.
- Hold m_roce_ack_ready=0 with an ACK pending → s_roce_rx_bth_ready=0. Release ready → descriptor consumed, the next header is accepted that cycle.
- With ROCE_RESP_RKEY_CHECK_EN defined, ONLY with r_key=0xDEAD vs init 0xBEEF → NAK syndrome 0x62, psn=ePSN. With the macro undefined, the same packet → ACK 0x1F.

Source files
------------

// File: rtl/roce_qp_responder.sv
// roce_qp_responder
//   Responder-side queue-pair state for RoCEv2 RC RDMA WRITE. Consumes decoded
//   RX BTH/RETH headers for the local QP, tracks the expected PSN (ePSN), MSN
//   and message sequencing, and emits ACK/NAK (BTH+AETH) descriptors toward
//   the TX header builder.
//
// Build option:
//   ROCE_RESP_RKEY_CHECK_EN - when defined, the RETH r_key of FIRST/ONLY is
//   compared with the QP r_key and a mismatch answers NAK 0x62. When
//   undefined, r_key is never a cause of NAK.
//
// Ports:
//   clk, rst (sync, active-low), rst_qp (sync, active-high QP re-init)
//   qp_init_*            QP context loaded on reset / rst_qp
//   s_roce_rx_bth_*      RX header stream (valid/ready), RETH fields qualified
//                        by s_roce_rx_reth_valid
//   m_roce_ack_*         ACK/NAK descriptor (valid/ready), registered
//   qp_epsn, qp_msn      current sequence state
//   qp_wr_addr/length    RETH address/length of the last FIRST/ONLY
//   msg_done             one-cycle pulse on an in-order LAST/ONLY
//   nak_active           high while waiting for a retransmit after a NAK
module roce_qp_responder #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rst_qp,
  input  logic [23:0]           qp_init_loc_qpn,
  input  logic [23:0]           qp_init_rem_qpn,
  input  logic [23:0]           qp_init_epsn,
  input  logic [31:0]           qp_init_r_key,
  input  logic                  s_roce_rx_bth_valid,
  output logic                  s_roce_rx_bth_ready,
  input  logic [7:0]            s_roce_rx_bth_op_code,
  input  logic [23:0]           s_roce_rx_bth_psn,
  input  logic [23:0]           s_roce_rx_bth_dest_qp,
  input  logic                  s_roce_rx_bth_ack_req,
  input  logic                  s_roce_rx_reth_valid,
  input  logic [63:0]           s_roce_rx_reth_v_addr,
  input  logic [31:0]           s_roce_rx_reth_r_key,
  input  logic [31:0]           s_roce_rx_reth_length,
  output logic                  m_roce_ack_valid,
  input  logic                  m_roce_ack_ready,
  output logic [7:0]            m_roce_ack_op_code,
  output logic [23:0]           m_roce_ack_psn,
  output logic [23:0]           m_roce_ack_dest_qp,
  output logic [7:0]            m_roce_ack_syndrome,
  output logic [23:0]           m_roce_ack_msn,
  output logic [23:0]           qp_epsn,
  output logic [23:0]           qp_msn,
  output logic [ADDR_WIDTH-1:0] qp_wr_addr,
  output logic [31:0]           qp_wr_length,
  output logic                  msg_done,
  output logic                  nak_active
);

  localparam logic [7:0] OP_WR_FIRST  = 8'h06;
  localparam logic [7:0] OP_WR_MIDDLE = 8'h07;
  localparam logic [7:0] OP_WR_LAST   = 8'h08;
  localparam logic [7:0] OP_WR_ONLY   = 8'h0A;
  localparam logic [7:0] OP_ACK       = 8'h11;

  localparam logic [7:0] SYN_ACK      = 8'h1F;
  localparam logic [7:0] SYN_PSN_ERR  = 8'h60;
  localparam logic [7:0] SYN_INV_REQ  = 8'h61;
  localparam logic [7:0] SYN_RMT_ACC  = 8'h62;

  typedef enum logic [1:0] {
    S_IDLE,
    S_IN_MSG,
    S_NAK_WAIT
  } state_t;

  state_t      state;
  logic [23:0] loc_qpn;
  logic [23:0] rem_qpn;

  // Modular PSN distance: d == 0 in order, 1..0x7FFFFF ahead, else duplicate.
  function automatic logic [23:0] psn_dist(input logic [23:0] psn, input logic [23:0] epsn);
    return psn - epsn;
  endfunction

  logic        hdr_take;
  logic [23:0] d_psn;
  logic        in_order;
  logic        ahead;
  logic        op_fo;
  logic        op_ml;
  logic        op_lo;
  logic        legal;
  logic        rkey_bad;

  logic        nx_ack;
  logic [23:0] nx_ack_psn;
  logic [7:0]  nx_ack_syn;
  logic [23:0] nx_ack_msn;
  logic [23:0] nx_epsn;
  logic [23:0] nx_msn;
  state_t      nx_state;
  logic        nx_latch;
  logic        nx_done;

`ifdef ROCE_RESP_RKEY_CHECK_EN
  logic [31:0] r_key;
  assign rkey_bad = (s_roce_rx_reth_r_key != r_key);
`else
  logic unused_rkey;
  assign unused_rkey = ^{s_roce_rx_reth_r_key, qp_init_r_key};
  assign rkey_bad    = 1'b0;
`endif

  assign s_roce_rx_bth_ready = !m_roce_ack_valid || m_roce_ack_ready;
  assign hdr_take = s_roce_rx_bth_valid && s_roce_rx_bth_ready &&
                    (s_roce_rx_bth_dest_qp == loc_qpn);

  assign d_psn    = psn_dist(s_roce_rx_bth_psn, qp_epsn);
  assign in_order = (d_psn == 24'd0);
  assign ahead    = (d_psn != 24'd0) && !d_psn[23];

  assign op_fo = (s_roce_rx_bth_op_code == OP_WR_FIRST) || (s_roce_rx_bth_op_code == OP_WR_ONLY);
  assign op_ml = (s_roce_rx_bth_op_code == OP_WR_MIDDLE) || (s_roce_rx_bth_op_code == OP_WR_LAST);
  assign op_lo = (s_roce_rx_bth_op_code == OP_WR_LAST) || (s_roce_rx_bth_op_code == OP_WR_ONLY);

  // NAK_WAIT is treated like IDLE for the FIRST/ONLY that ends it.
  assign legal = (state == S_IN_MSG) ? op_ml : (op_fo && s_roce_rx_reth_valid);

  always_comb begin
    nx_ack     = 1'b0;
    nx_ack_psn = s_roce_rx_bth_psn;
    nx_ack_syn = SYN_ACK;
    nx_ack_msn = qp_msn;
    nx_epsn    = qp_epsn;
    nx_msn     = qp_msn;
    nx_state   = state;
    nx_latch   = 1'b0;
    nx_done    = 1'b0;
    if (hdr_take) begin
      if (in_order) begin
        if (state == S_NAK_WAIT && !op_fo) begin
          // Only a FIRST/ONLY can end the NAK wait; anything else is dropped.
          nx_state = state;
        end else if (!legal) begin
          nx_ack     = 1'b1;
          nx_ack_syn = SYN_INV_REQ;
          nx_ack_psn = qp_epsn;
          nx_state   = S_NAK_WAIT;
        end else if (op_fo && rkey_bad) begin
          nx_ack     = 1'b1;
          nx_ack_syn = SYN_RMT_ACC;
          nx_ack_psn = qp_epsn;
          nx_state   = S_NAK_WAIT;
        end else begin
          nx_epsn  = qp_epsn + 24'd1;
          nx_latch = op_fo;
          if (s_roce_rx_bth_op_code == OP_WR_FIRST) begin
            nx_state = S_IN_MSG;
          end else if (op_lo) begin
            nx_state = S_IDLE;
            nx_msn   = qp_msn + 24'd1;
            nx_done  = 1'b1;
          end
          if (s_roce_rx_bth_ack_req || op_lo) begin
            nx_ack     = 1'b1;
            nx_ack_msn = nx_msn;
          end
        end
      end else if (ahead) begin
        if (state != S_NAK_WAIT) begin
          nx_ack     = 1'b1;
          nx_ack_syn = SYN_PSN_ERR;
          nx_ack_psn = qp_epsn;
          nx_state   = S_NAK_WAIT;
        end
      end else if (s_roce_rx_bth_ack_req) begin
        // Duplicate: re-acknowledge everything up to ePSN-1.
        nx_ack     = 1'b1;
        nx_ack_psn = qp_epsn - 24'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || rst_qp) begin
      state               <= S_IDLE;
      loc_qpn             <= qp_init_loc_qpn;
      rem_qpn             <= qp_init_rem_qpn;
`ifdef ROCE_RESP_RKEY_CHECK_EN
      r_key               <= qp_init_r_key;
`endif
      qp_epsn             <= qp_init_epsn;
      qp_msn              <= 24'd0;
      qp_wr_addr          <= '0;
      qp_wr_length        <= 32'd0;
      msg_done            <= 1'b0;
      nak_active          <= 1'b0;
      m_roce_ack_valid    <= 1'b0;
      m_roce_ack_op_code  <= 8'd0;
      m_roce_ack_psn      <= 24'd0;
      m_roce_ack_dest_qp  <= 24'd0;
      m_roce_ack_syndrome <= 8'd0;
      m_roce_ack_msn      <= 24'd0;
    end else begin
      state      <= nx_state;
      qp_epsn    <= nx_epsn;
      qp_msn     <= nx_msn;
      msg_done   <= nx_done;
      nak_active <= (nx_state == S_NAK_WAIT);
      if (nx_latch) begin
        qp_wr_addr   <= s_roce_rx_reth_v_addr[ADDR_WIDTH-1:0];
        qp_wr_length <= s_roce_rx_reth_length;
      end
      // A header is only taken when the slot is free or draining this cycle,
      // so a new descriptor may overwrite the one being consumed.
      if (m_roce_ack_valid && m_roce_ack_ready) begin
        m_roce_ack_valid <= 1'b0;
      end
      if (nx_ack) begin
        m_roce_ack_valid    <= 1'b1;
        m_roce_ack_op_code  <= OP_ACK;
        m_roce_ack_psn      <= nx_ack_psn;
        m_roce_ack_dest_qp  <= rem_qpn;
        m_roce_ack_syndrome <= nx_ack_syn;
        m_roce_ack_msn      <= nx_ack_msn;
      end
    end
  end

endmodule
